floating_point_adder_pipelined: RTL and testbench

- Parametrised, pipelined successor to the combinational floating-point adder.
- Three-stage pipeline: align, add/normalise, round. Valid/ready handshake on input and output, with per-stage bubble collapsing.
- Rounding mode is selected per operation at run time. A user tag travels with each operation.
- Sits between operand-issue logic and result writeback in the datapath.

---
 rtl/floating_point_adder_pipelined.sv | 235 +++++++++++++++++++++++
 tb/tb_floating_point_adder_pipelined.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floating_point_adder_pipelined.sv
// Three-stage pipelined floating-point adder (align, add/normalise, round)
// with valid/ready handshake, per-operation rounding mode and a tag.
module floating_point_adder_pipelined #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int ROUNDING_BITS  = 3,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]     a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]     b,
  input  logic                                       subtract,
  input  logic                                       round_mode,
  input  logic [TAG_WIDTH-1:0]                       in_tag,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]     out,
  output logic [TAG_WIDTH-1:0]                       out_tag,
  output logic                                       underflow_flag,
  output logic                                       overflow_flag,
  output logic                                       invalid_operation_flag
);
  localparam int EW = EXPONENT_WIDTH;
  localparam int MW = MANTISSA_WIDTH;
  localparam int RW = ROUNDING_BITS;
  localparam int XW = MW + 1 + RW;
  localparam int FW = EW + MW + 1;
  localparam logic [EW-1:0] EXP_ONES = {EW{1'b1}};
  localparam logic [FW-1:0] QNAN = {1'b1, EXP_ONES, 1'b1, {(MW-1){1'b0}}};

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF} special_t;

  logic v1, v2, v3, ld1, ld2, ld3;
  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
    end
  end

  // ---------------- stage 1: classify and align ----------------
  logic          sa, sb_raw, sb;
  logic [EW-1:0] exp_a, exp_b, ea_eff, eb_eff, big_e, small_e, diff;
  logic [MW-1:0] man_a, man_b;
  logic [XW-1:0] ext_a, ext_b, big_m, small_m, aligned;
  logic          nan_a, nan_b, inf_a, inf_b, swap, big_s, sticky, sp_sign;
  special_t      sp;

  assign {sa, exp_a, man_a}     = a;
  assign {sb_raw, exp_b, man_b} = b;
  assign sb     = sb_raw ^ subtract;
  assign nan_a  = (exp_a == EXP_ONES) && (man_a != '0);
  assign nan_b  = (exp_b == EXP_ONES) && (man_b != '0);
  assign inf_a  = (exp_a == EXP_ONES) && (man_a == '0);
  assign inf_b  = (exp_b == EXP_ONES) && (man_b == '0);
  // Subnormals share the exponent of the smallest normal for alignment.
  assign ea_eff = (exp_a == '0) ? {{(EW-1){1'b0}}, 1'b1} : exp_a;
  assign eb_eff = (exp_b == '0) ? {{(EW-1){1'b0}}, 1'b1} : exp_b;
  assign ext_a  = {(exp_a != '0), man_a, {RW{1'b0}}};
  assign ext_b  = {(exp_b != '0), man_b, {RW{1'b0}}};
  assign swap   = {exp_b, man_b} > {exp_a, man_a};
  assign big_e   = swap ? eb_eff : ea_eff;
  assign small_e = swap ? ea_eff : eb_eff;
  assign big_m   = swap ? ext_b : ext_a;
  assign small_m = swap ? ext_a : ext_b;
  assign big_s   = swap ? sb : sa;
  assign diff    = big_e - small_e;

  always_comb begin
    aligned = '0;
    sticky  = |small_m;
    if (32'(diff) < XW) begin
      aligned = small_m >> diff;
      sticky  = |(small_m & ~({XW{1'b1}} << diff));
    end
    aligned[0] = aligned[0] | sticky;
  end

  always_comb begin
    sp      = SP_NONE;
    sp_sign = 1'b0;
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      sp = SP_NAN;
    end else if (inf_a) begin
      sp      = SP_INF;
      sp_sign = sa;
    end else if (inf_b) begin
      sp      = SP_INF;
      sp_sign = sb;
    end
  end

  special_t       s1_sp;
  logic           s1_sign, s1_sub, s1_zero_sign, s1_rm;
  logic [EW-1:0]  s1_exp;
  logic [XW-1:0]  s1_big, s1_small;
  logic [TAG_WIDTH-1:0] s1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sp <= SP_NONE; s1_sign <= 1'b0; s1_sub <= 1'b0; s1_zero_sign <= 1'b0;
      s1_rm <= 1'b0; s1_exp <= '0; s1_big <= '0; s1_small <= '0; s1_tag <= '0;
    end else if (ld1 && in_valid) begin
      s1_sp        <= sp;
      s1_sign      <= (sp == SP_INF) ? sp_sign : big_s;
      s1_sub       <= sa != sb;
      s1_zero_sign <= sa && sb;
      s1_rm        <= round_mode;
      s1_exp       <= big_e;
      s1_big       <= big_m;
      s1_small     <= aligned;
      s1_tag       <= in_tag;
    end
  end

  // ---------------- stage 2: add and normalise ----------------
  logic [XW:0]   sum;
  logic [31:0]   lz;
  logic          found, n_sign, n_uf;
  logic [XW-1:0] n_mant;
  logic [EW-1:0] n_exp;

  assign sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                      : ({1'b0, s1_big} + {1'b0, s1_small});

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = XW - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz = lz + 32'd1;
      end
    end
  end

  // A zero result is encoded as a cleared leading bit in the normalised mantissa.
  always_comb begin
    n_mant = '0;
    n_exp  = s1_exp;
    n_sign = s1_sign;
    n_uf   = 1'b0;
    if (sum[XW]) begin
      n_mant = sum[XW:1] | {{(XW-1){1'b0}}, sum[0]};
      n_exp  = s1_exp + 1'b1;
    end else if (sum[XW-1:0] == '0) begin
      n_sign = s1_zero_sign;
    end else if (32'(s1_exp) <= lz) begin
      n_uf = 1'b1;
    end else begin
      n_mant = sum[XW-1:0] << lz;
      n_exp  = s1_exp - EW'(lz);
    end
  end

  special_t       s2_sp;
  logic           s2_sign, s2_uf, s2_rm;
  logic [EW-1:0]  s2_exp;
  logic [XW-1:0]  s2_mant;
  logic [TAG_WIDTH-1:0] s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sp <= SP_NONE; s2_sign <= 1'b0; s2_uf <= 1'b0; s2_rm <= 1'b0;
      s2_exp <= '0; s2_mant <= '0; s2_tag <= '0;
    end else if (ld2 && v1) begin
      s2_sp   <= s1_sp;
      s2_sign <= (s1_sp != SP_NONE) ? s1_sign : n_sign;
      s2_uf   <= n_uf;
      s2_rm   <= s1_rm;
      s2_exp  <= n_exp;
      s2_mant <= n_mant;
      s2_tag  <= s1_tag;
    end
  end

  // ---------------- stage 3: round and pack ----------------
  logic          guard, rest, lsb, inc, rcarry, r_uf, r_of, r_inv;
  logic [MW-1:0] r_mant;
  logic [EW:0]   r_exp;
  logic [FW-1:0] r_out;

  assign guard = s2_mant[RW-1];
  assign rest  = |s2_mant[RW-2:0];
  assign lsb   = s2_mant[RW];
  assign inc   = s2_rm && guard && (rest || lsb);
  assign {rcarry, r_mant} = {1'b0, s2_mant[XW-2:RW]} + {{MW{1'b0}}, inc};
  assign r_exp = {1'b0, s2_exp} + {{EW{1'b0}}, rcarry};

  always_comb begin
    r_out = {s2_sign, r_exp[EW-1:0], r_mant};
    r_uf  = 1'b0;
    r_of  = 1'b0;
    r_inv = 1'b0;
    if (s2_sp == SP_NAN) begin
      r_out = QNAN;
      r_inv = 1'b1;
    end else if (s2_sp == SP_INF) begin
      r_out = {s2_sign, EXP_ONES, {MW{1'b0}}};
    end else if (!s2_mant[XW-1]) begin
      r_out = {s2_sign, {(FW-1){1'b0}}};
      r_uf  = s2_uf;
    end else if (r_exp >= {1'b0, EXP_ONES}) begin
      r_out = {s2_sign, EXP_ONES, {MW{1'b0}}};
      r_of  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0; out_tag <= '0;
      underflow_flag <= 1'b0; overflow_flag <= 1'b0; invalid_operation_flag <= 1'b0;
    end else if (ld3 && v2) begin
      out                    <= r_out;
      out_tag                <= s2_tag;
      underflow_flag         <= r_uf;
      overflow_flag          <= r_of;
      invalid_operation_flag <= r_inv;
    end
  end
endmodule

// File: tb/tb_floating_point_adder_pipelined.sv
// Directed bench for floating_point_adder_pipelined (single precision, 4-bit tag).
module tb_floating_point_adder_pipelined;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, subtract = 1'b0, round_mode = 1'b1;
  logic [31:0] a = '0, b = '0, out;
  logic [3:0]  in_tag = '0, out_tag;
  logic        out_valid, out_ready = 1'b1;
  logic        underflow_flag, overflow_flag, invalid_operation_flag;
  int          total = 0, bad = 0;

  floating_point_adder_pipelined dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .subtract(subtract), .round_mode(round_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_tag(out_tag),
    .underflow_flag(underflow_flag), .overflow_flag(overflow_flag),
    .invalid_operation_flag(invalid_operation_flag)
  );

  always #5 clk = ~clk;

  // Issue one op with an idle pipeline and collect its result; lat counts edges
  // from the transfer edge (inclusive) to the edge that raises out_valid.
  task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input logic sub,
                        input logic rm, input logic [3:0] tg, output logic [31:0] res,
                        output logic [3:0] otg, output logic [2:0] flg, output int lat);
    @(posedge clk); #1;
    a = aa; b = bb; subtract = sub; round_mode = rm; in_tag = tg;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); lat = 1; #1;
    in_valid = 1'b0; a = '1; b = '1; subtract = ~sub; round_mode = ~rm; in_tag = ~tg;
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++; #1;
    end
    res = out; otg = out_tag;
    flg = {underflow_flag, overflow_flag, invalid_operation_flag};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (out_valid !== 1'b0 || out !== 32'h0 || out_tag !== 4'h0 ||
        {underflow_flag, overflow_flag, invalid_operation_flag} !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b out=%h tag=%h flags=%b want 0", out_valid, out,
               out_tag, {underflow_flag, overflow_flag, invalid_operation_flag});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] va[5] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h40400000, 32'h40000000};
    logic [31:0] vb[5] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800000};
    logic        vs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] ve[5] = '{32'h40000000, 32'h00000000, 32'h80000000, 32'h40800000, 32'h3F800000};
    logic [31:0] res; logic [3:0] otg; logic [2:0] flg; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vs[i], 1'b1, 4'(i + 3), res, otg, flg, lat);
      total++;
      if (res !== ve[i] || flg !== 3'b000 || otg !== 4'(i + 3) || lat != 3) begin
        bad++;
        $display("FAIL basic[%0d]: got out=%h flags=%b tag=%h lat=%0d want out=%h flags=000 tag=%h lat=3",
                 i, res, flg, otg, lat, ve[i], 4'(i + 3));
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] vb[5] = '{32'h33800000, 32'h33C00000, 32'h33C00000, 32'h33800000, 32'h33800000};
    logic [31:0] va[5] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h3F800001};
    logic        vr[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ve[5] = '{32'h3F800000, 32'h3F800001, 32'h3F800000, 32'h3F800002, 32'h3F800001};
    logic [31:0] res; logic [3:0] otg; logic [2:0] flg; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], 1'b0, vr[i], 4'(i), res, otg, flg, lat);
      total++;
      if (res !== ve[i] || flg !== 3'b000 || otg !== 4'(i)) begin
        bad++;
        $display("FAIL rounding[%0d]: got out=%h flags=%b tag=%h want out=%h flags=000 tag=%h",
                 i, res, flg, otg, ve[i], 4'(i));
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] va[5] = '{32'h7F800000, 32'h7F800000, 32'h7F800000, 32'h3F800000, 32'h7FC00001};
    logic [31:0] vb[5] = '{32'hFF800000, 32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h3F800000};
    logic        vs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ve[5] = '{32'hFFC00000, 32'hFFC00000, 32'h7F800000, 32'hFF800000, 32'hFFC00000};
    logic [2:0]  vf[5] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b001};
    logic [31:0] res; logic [3:0] otg; logic [2:0] flg; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vs[i], 1'b1, 4'(9 + i), res, otg, flg, lat);
      total++;
      if (res !== ve[i] || flg !== vf[i] || otg !== 4'(9 + i)) begin
        bad++;
        $display("FAIL special[%0d]: got out=%h flags=%b tag=%h want out=%h flags=%b tag=%h",
                 i, res, flg, otg, ve[i], vf[i], 4'(9 + i));
      end
    end
  endtask

  task automatic test_exceptions();
    logic [31:0] va[3] = '{32'h7F7FFFFF, 32'h00800000, 32'hFF7FFFFF};
    logic [31:0] vb[3] = '{32'h7F7FFFFF, 32'h00800001, 32'hFF7FFFFF};
    logic        vs[3] = '{1'b0, 1'b1, 1'b0};
    logic        vr[3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] ve[3] = '{32'h7F800000, 32'h80000000, 32'hFF800000};
    logic [2:0]  vf[3] = '{3'b010, 3'b100, 3'b010};
    logic [31:0] res; logic [3:0] otg; logic [2:0] flg; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vs[i], vr[i], 4'(14 - i), res, otg, flg, lat);
      total++;
      if (res !== ve[i] || flg !== vf[i] || otg !== 4'(14 - i)) begin
        bad++;
        $display("FAIL exception[%0d]: got out=%h flags=%b tag=%h want out=%h flags=%b tag=%h",
                 i, res, flg, otg, ve[i], vf[i], 4'(14 - i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] ve[4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    int recv = 0, first = -1, last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      if (out_valid && recv < 4) begin
        total++;
        if (out !== ve[recv] || out_tag !== 4'(recv) || (recv > 0 && cyc != last + 1)) begin
          bad++;
          $display("FAIL b2b[%0d]: got out=%h tag=%h cyc=%0d want out=%h tag=%h cyc=%0d",
                   recv, out, out_tag, cyc, ve[recv], 4'(recv), last + 1);
        end
        if (recv == 0) first = cyc;
        last = cyc;
        recv++;
      end
      if (cyc < 4) begin
        a = va[cyc]; b = 32'h3F800000; subtract = 1'b0; round_mode = 1'b1;
        in_tag = 4'(cyc); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    total++;
    if (recv != 4 || first != 3) begin
      bad++;
      $display("FAIL b2b_count: got recv=%0d first=%0d want recv=4 first=3", recv, first);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] va[8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] ve[8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                           32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
    logic [3:0]  pat = 4'b1001;
    logic [31:0] held = '0;
    logic [3:0]  held_tag = '0;
    logic        stalled = 1'b0, xfer = 1'b0;
    int sent = 0, recv = 0, occ = 0, gap = 1;
    for (int k = 0; k < 300 && recv < 8; k++) begin
      @(posedge clk); #1;
      if (xfer) in_valid = 1'b0;
      xfer = 1'b0;
      out_ready = pat[k % 4];
      if (!in_valid && sent < 8) begin
        if (gap == 0) begin
          a = va[sent]; b = 32'h3F800000; subtract = 1'b0; round_mode = 1'b1;
          in_tag = 4'(sent); in_valid = 1'b1;
        end else gap--;
      end
      #1;
      total++;
      if (in_ready !== !(occ == 3 && !out_ready)) begin
        bad++;
        $display("FAIL bp_in_ready: got %b want %b (occ=%0d out_ready=%b)", in_ready,
                 !(occ == 3 && !out_ready), occ, out_ready);
      end
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || out !== held || out_tag !== held_tag) begin
          bad++;
          $display("FAIL bp_hold: got valid=%b out=%h tag=%h want valid=1 out=%h tag=%h",
                   out_valid, out, out_tag, held, held_tag);
        end
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          total++;
          if (recv >= 8 || out !== ve[recv] || out_tag !== 4'(recv)) begin
            bad++;
            $display("FAIL bp_result[%0d]: got out=%h tag=%h want out=%h tag=%h", recv, out,
                     out_tag, ve[recv % 8], 4'(recv));
          end
          recv++; occ--;
        end else begin
          stalled = 1'b1; held = out; held_tag = out_tag;
        end
      end
      if (in_valid && in_ready) begin
        sent++; occ++; xfer = 1'b1;
        gap = int'($urandom_range(0, 2));
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (recv != 8 || sent != 8 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_count: got recv=%0d sent=%0d valid=%b want recv=8 sent=8 valid=0",
               recv, sent, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] res; logic [3:0] otg; logic [2:0] flg; int lat, stale = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 32'h3F800000; b = 32'h3F800000; subtract = 1'b0; in_tag = 4'(5 + i); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_pipe: got valid=%b in_ready=%b want valid=1 in_ready=0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out !== 32'h0) begin
      bad++;
      $display("FAIL midreset_valid: got valid=%b out=%h want valid=0 out=0", out_valid, out);
    end
    out_ready = 1'b1;
    #20;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL midreset_stale: got %0d stale cycles want 0", stale);
    end
    run_op(32'h40000000, 32'h40000000, 1'b0, 1'b1, 4'hA, res, otg, flg, lat);
    total++;
    if (res !== 32'h40800000 || otg !== 4'hA || flg !== 3'b000 || lat != 3) begin
      bad++;
      $display("FAIL midreset_next: got out=%h tag=%h flags=%b lat=%0d want out=40800000 tag=a flags=000 lat=3",
               res, otg, flg, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_exceptions();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
